// File: rtl/ul_addr_demux.sv
// TL-UL 1:2 address demultiplexer: routes host A requests to first/second by a_address[SEL_BIT],
// returns D responses in order. Define UL_DEMUX_ERR_EN to answer unmapped addresses with an error.
module ul_addr_demux #(
  parameter int TL_AW           = 32,
  parameter int TL_DW           = 32,
  parameter int TL_AIW          = 8,
  parameter int TL_DIW          = 1,
  parameter int TL_DBW          = TL_DW >> 3,
  parameter int TL_SZW          = $clog2($clog2(TL_DBW) + 1),
  parameter int SEL_BIT         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  // host A
  input  logic              a_valid,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [TL_SZW-1:0] a_size,
  input  logic [TL_AIW-1:0] a_source,
  input  logic [TL_AW-1:0]  a_address,
  input  logic [TL_DBW-1:0] a_mask,
  input  logic [TL_DW-1:0]  a_data,
  output logic              a_ready,
  // host D
  output logic              d_valid,
  output logic [2:0]        d_opcode,
  output logic [2:0]        d_param,
  output logic [TL_SZW-1:0] d_size,
  output logic [TL_AIW-1:0] d_source,
  output logic [TL_DIW-1:0] d_sink,
  output logic [TL_DW-1:0]  d_data,
  output logic              d_error,
  input  logic              d_ready,
  // first target
  output logic              first_a_valid,
  output logic [2:0]        first_a_opcode,
  output logic [2:0]        first_a_param,
  output logic [TL_SZW-1:0] first_a_size,
  output logic [TL_AIW-1:0] first_a_source,
  output logic [TL_AW-1:0]  first_a_address,
  output logic [TL_DBW-1:0] first_a_mask,
  output logic [TL_DW-1:0]  first_a_data,
  input  logic              first_a_ready,
  input  logic              first_d_valid,
  input  logic [2:0]        first_d_opcode,
  input  logic [2:0]        first_d_param,
  input  logic [TL_SZW-1:0] first_d_size,
  input  logic [TL_AIW-1:0] first_d_source,
  input  logic [TL_DIW-1:0] first_d_sink,
  input  logic [TL_DW-1:0]  first_d_data,
  input  logic              first_d_error,
  output logic              first_d_ready,
  // second target
  output logic              second_a_valid,
  output logic [2:0]        second_a_opcode,
  output logic [2:0]        second_a_param,
  output logic [TL_SZW-1:0] second_a_size,
  output logic [TL_AIW-1:0] second_a_source,
  output logic [TL_AW-1:0]  second_a_address,
  output logic [TL_DBW-1:0] second_a_mask,
  output logic [TL_DW-1:0]  second_a_data,
  input  logic              second_a_ready,
  input  logic              second_d_valid,
  input  logic [2:0]        second_d_opcode,
  input  logic [2:0]        second_d_param,
  input  logic [TL_SZW-1:0] second_d_size,
  input  logic [TL_AIW-1:0] second_d_source,
  input  logic [TL_DIW-1:0] second_d_sink,
  input  logic [TL_DW-1:0]  second_d_data,
  input  logic              second_d_error,
  output logic              second_d_ready
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  localparam logic [1:0] TGT_FIRST  = 2'd0;
  localparam logic [1:0] TGT_SECOND = 2'd1;
  localparam logic [1:0] TGT_ERR    = 2'd2;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;

  logic       sel;
  logic       unmapped;
  logic [1:0] req_tgt;
  logic       can_issue;
  logic       a_hs;
  logic       d_hs;

  assign sel = a_address[SEL_BIT];

`ifdef UL_DEMUX_ERR_EN
  assign unmapped = |a_address[TL_AW-1:SEL_BIT+1];
`else
  assign unmapped = 1'b0;
`endif

  assign req_tgt = unmapped ? TGT_ERR : (sel ? TGT_SECOND : TGT_FIRST);

  // An unmapped request may only start from an idle block; mapped ones may join the current target.
  assign can_issue = (cnt_q == CNT_ZERO) ||
                     (!unmapped && tgt_q == req_tgt && cnt_q < CNT_MAX);

  // Payload fans out unchanged; only valid is steered.
  assign first_a_opcode   = a_opcode;
  assign first_a_param    = a_param;
  assign first_a_size     = a_size;
  assign first_a_source   = a_source;
  assign first_a_address  = a_address;
  assign first_a_mask     = a_mask;
  assign first_a_data     = a_data;
  assign second_a_opcode  = a_opcode;
  assign second_a_param   = a_param;
  assign second_a_size    = a_size;
  assign second_a_source  = a_source;
  assign second_a_address = a_address;
  assign second_a_mask    = a_mask;
  assign second_a_data    = a_data;

  assign first_a_valid  = !rst && a_valid && !unmapped && !sel && can_issue;
  assign second_a_valid = !rst && a_valid && !unmapped &&  sel && can_issue;
  assign a_ready        = !rst && can_issue &&
                          (unmapped ? 1'b1 : (sel ? second_a_ready : first_a_ready));

`ifdef UL_DEMUX_ERR_EN
  logic [2:0]        err_opcode_q, err_opcode_d;
  logic [2:0]        err_param_q,  err_param_d;
  logic [TL_SZW-1:0] err_size_q,   err_size_d;
  logic [TL_AIW-1:0] err_source_q, err_source_d;

  always_comb begin
    err_opcode_d = err_opcode_q;
    err_param_d  = err_param_q;
    err_size_d   = err_size_q;
    err_source_d = err_source_q;
    if (a_hs && unmapped) begin
      err_opcode_d = (a_opcode == 3'd4) ? 3'd1 : 3'd0;
      err_param_d  = a_param;
      err_size_d   = a_size;
      err_source_d = a_source;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_opcode_q <= '0;
      err_param_q  <= '0;
      err_size_q   <= '0;
      err_source_q <= '0;
    end else begin
      err_opcode_q <= err_opcode_d;
      err_param_q  <= err_param_d;
      err_size_q   <= err_size_d;
      err_source_q <= err_source_d;
    end
  end
`endif

  // NOTE: every output is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    d_valid        = 1'b0;
    first_d_ready  = 1'b0;
    second_d_ready = 1'b0;
    d_opcode       = first_d_opcode;
    d_param        = first_d_param;
    d_size         = first_d_size;
    d_source       = first_d_source;
    d_sink         = first_d_sink;
    d_data         = first_d_data;
    d_error        = first_d_error;
    case (tgt_q)
      TGT_SECOND: begin
        d_opcode = second_d_opcode;
        d_param  = second_d_param;
        d_size   = second_d_size;
        d_source = second_d_source;
        d_sink   = second_d_sink;
        d_data   = second_d_data;
        d_error  = second_d_error;
        if (!rst && cnt_q != CNT_ZERO) begin
          d_valid        = second_d_valid;
          second_d_ready = d_ready;
        end
      end
`ifdef UL_DEMUX_ERR_EN
      TGT_ERR: begin
        d_opcode = err_opcode_q;
        d_param  = err_param_q;
        d_size   = err_size_q;
        d_source = err_source_q;
        d_sink   = '0;
        d_data   = '0;
        d_error  = 1'b1;
        d_valid  = !rst && cnt_q != CNT_ZERO;
      end
`endif
      default: begin
        if (!rst && cnt_q != CNT_ZERO) begin
          d_valid       = first_d_valid;
          first_d_ready = d_ready;
        end
      end
    endcase
  end

  assign a_hs = a_valid && a_ready;
  assign d_hs = d_valid && d_ready;

  always_comb begin
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    if (a_hs) tgt_d = req_tgt;
    case ({a_hs, d_hs})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
      tgt_q <= TGT_FIRST;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

endmodule
